// File: rtl/blob_bbox_tracker.sv
// Scans one stored frame through a synchronous frame memory, thresholds pixels inside an ROI,
// and reports hit count, bounding box and centre touch point with a one-cycle ready pulse.
module blob_bbox_tracker #(
   parameter int HSIZE     = 640,
   parameter int VSIZE     = 480,
   parameter int PIX_W     = 8,
   parameter int CW        = 10,
   parameter int AW        = 18,
   parameter int MIN_COUNT = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             frame_available,
   input  logic [PIX_W-1:0] threshold,
   input  logic [CW-1:0]    roi_tl_h,
   input  logic [CW-1:0]    roi_tl_v,
   input  logic [CW-1:0]    roi_br_h,
   input  logic [CW-1:0]    roi_br_v,
   output logic [AW-1:0]    bin_index,
   input  logic [PIX_W-1:0] pixel_val,
   output logic             busy,
   output logic [CW-1:0]    bbox_min_h,
   output logic [CW-1:0]    bbox_min_v,
   output logic [CW-1:0]    bbox_max_h,
   output logic [CW-1:0]    bbox_max_v,
   output logic [19:0]      hit_count,
   output logic             touch,
   output logic [CW-1:0]    touch_h,
   output logic [CW-1:0]    touch_v,
   output logic             touch_ready
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [CW-1:0] H_LAST   = CW'(HSIZE - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(VSIZE - 1);
   localparam logic [AW-1:0] ROW_STEP = AW'(HSIZE);
   localparam logic [19:0]   MIN_CNT  = 20'(MIN_COUNT);

   function automatic logic [19:0] sat_inc(input logic [19:0] c);
      return (c == 20'hFFFFF) ? c : c + 20'd1;
   endfunction

   function automatic logic [CW-1:0] midpoint(input logic [CW-1:0] a, input logic [CW-1:0] b);
      logic [CW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CW:1];
   endfunction

   state_t           state_q, state_d;
   logic             pending_q, pending_d, scan_end_q, scan_end_d;
   logic [CW-1:0]    h_q, h_d, v_q, v_d;
   logic [AW-1:0]    row_q, row_d, bin_index_q, bin_index_d;
   logic             vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
   logic             busy_q, busy_d, touch_ready_q, touch_ready_d;
   logic [19:0]      cnt_q, cnt_d, hit_count_q, hit_count_d;
   logic [CW-1:0]    min_h_q, min_h_d, min_v_q, min_v_d, max_h_q, max_h_d, max_v_q, max_v_d;
   logic [CW-1:0]    bbox_min_h_q, bbox_min_h_d, bbox_min_v_q, bbox_min_v_d;
   logic [CW-1:0]    bbox_max_h_q, bbox_max_h_d, bbox_max_v_q, bbox_max_v_d;
   logic             touch_q, touch_d;
   logic [CW-1:0]    touch_h_q, touch_h_d, touch_v_q, touch_v_d;
   logic [PIX_W-1:0] thr_q, thr_d;
   logic [CW-1:0]    tl_h_q, tl_h_d, tl_v_q, tl_v_d, br_h_q, br_h_d, br_v_q, br_v_d;
   logic [CW-1:0]    h_p0_q, h_p0_d, v_p0_q, v_p0_d, h_p1_q, h_p1_d, v_p1_q, v_p1_d;
   logic             start, hit;

   always_comb begin
      start = (state_q == IDLE) && (frame_available || pending_q);
      hit   = vld_p1_q && (pixel_val >= thr_q)
              && (h_p1_q >= tl_h_q) && (h_p1_q <= br_h_q)
              && (v_p1_q >= tl_v_q) && (v_p1_q <= br_v_q);
   end

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      scan_end_d    = scan_end_q;
      h_d           = h_q;
      v_d           = v_q;
      row_d         = row_q;
      bin_index_d   = bin_index_q;
      vld_p0_d      = 1'b0;
      vld_p1_d      = vld_p0_q;
      busy_d        = (state_q == SCAN);
      touch_ready_d = 1'b0;
      cnt_d         = cnt_q;
      min_h_d       = min_h_q;
      min_v_d       = min_v_q;
      max_h_d       = max_h_q;
      max_v_d       = max_v_q;
      hit_count_d   = hit_count_q;
      bbox_min_h_d  = bbox_min_h_q;
      bbox_min_v_d  = bbox_min_v_q;
      bbox_max_h_d  = bbox_max_h_q;
      bbox_max_v_d  = bbox_max_v_q;
      touch_d       = touch_q;
      touch_h_d     = touch_h_q;
      touch_v_d     = touch_v_q;
      thr_d         = start ? threshold : thr_q;
      tl_h_d        = start ? roi_tl_h : tl_h_q;
      tl_v_d        = start ? roi_tl_v : tl_v_q;
      br_h_d        = start ? roi_br_h : br_h_q;
      br_v_d        = start ? roi_br_v : br_v_q;
      // address stage coordinates, then the stage aligned with pixel_val
      h_p0_d        = h_q;
      v_p0_d        = v_q;
      h_p1_d        = h_p0_q;
      v_p1_d        = v_p0_q;

      if (hit) begin
         cnt_d = sat_inc(cnt_q);
         if (h_p1_q < min_h_q) min_h_d = h_p1_q;
         if (v_p1_q < min_v_q) min_v_d = v_p1_q;
         if (h_p1_q > max_h_q) max_h_d = h_p1_q;
         if (v_p1_q > max_v_q) max_v_d = v_p1_q;
      end

      if (frame_available && (state_q != IDLE)) pending_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SCAN;
               pending_d  = 1'b0;
               scan_end_d = 1'b0;
               h_d        = '0;
               v_d        = '0;
               row_d      = '0;
               cnt_d      = '0;
               min_h_d    = '1;
               min_v_d    = '1;
               max_h_d    = '0;
               max_v_d    = '0;
            end
         end
         SCAN: begin
            if (scan_end_q) begin
               state_d = DRAIN;
            end else begin
               bin_index_d = row_q + AW'(h_q);
               vld_p0_d    = 1'b1;
               if (h_q == H_LAST) begin
                  h_d        = '0;
                  v_d        = v_q + CW'(1);
                  row_d      = row_q + ROW_STEP;
                  scan_end_d = (v_q == V_LAST);
               end else begin
                  h_d = h_q + CW'(1);
               end
            end
         end
         DRAIN: begin
            // the final pixel lands on this edge, so results come from the next-state accumulators
            state_d       = DONE;
            touch_ready_d = 1'b1;
            hit_count_d   = cnt_d;
            if (cnt_d == '0) begin
               bbox_min_h_d = '0;
               bbox_min_v_d = '0;
               bbox_max_h_d = '0;
               bbox_max_v_d = '0;
               touch_d      = 1'b0;
               touch_h_d    = '0;
               touch_v_d    = '0;
            end else begin
               bbox_min_h_d = min_h_d;
               bbox_min_v_d = min_v_d;
               bbox_max_h_d = max_h_d;
               bbox_max_v_d = max_v_d;
               touch_d      = (cnt_d >= MIN_CNT);
               touch_h_d    = midpoint(min_h_d, max_h_d);
               touch_v_d    = midpoint(min_v_d, max_v_d);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pending_q     <= 1'b0;
         scan_end_q    <= 1'b0;
         h_q           <= '0;
         v_q           <= '0;
         row_q         <= '0;
         bin_index_q   <= '0;
         vld_p0_q      <= 1'b0;
         vld_p1_q      <= 1'b0;
         busy_q        <= 1'b0;
         touch_ready_q <= 1'b0;
         cnt_q         <= '0;
         min_h_q       <= '0;
         min_v_q       <= '0;
         max_h_q       <= '0;
         max_v_q       <= '0;
         hit_count_q   <= '0;
         bbox_min_h_q  <= '0;
         bbox_min_v_q  <= '0;
         bbox_max_h_q  <= '0;
         bbox_max_v_q  <= '0;
         touch_q       <= 1'b0;
         touch_h_q     <= '0;
         touch_v_q     <= '0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         scan_end_q    <= scan_end_d;
         h_q           <= h_d;
         v_q           <= v_d;
         row_q         <= row_d;
         bin_index_q   <= bin_index_d;
         vld_p0_q      <= vld_p0_d;
         vld_p1_q      <= vld_p1_d;
         busy_q        <= busy_d;
         touch_ready_q <= touch_ready_d;
         cnt_q         <= cnt_d;
         min_h_q       <= min_h_d;
         min_v_q       <= min_v_d;
         max_h_q       <= max_h_d;
         max_v_q       <= max_v_d;
         hit_count_q   <= hit_count_d;
         bbox_min_h_q  <= bbox_min_h_d;
         bbox_min_v_q  <= bbox_min_v_d;
         bbox_max_h_q  <= bbox_max_h_d;
         bbox_max_v_q  <= bbox_max_v_d;
         touch_q       <= touch_d;
         touch_h_q     <= touch_h_d;
         touch_v_q     <= touch_v_d;
      end
   end

   always_ff @(posedge clock) begin
      thr_q  <= thr_d;
      tl_h_q <= tl_h_d;
      tl_v_q <= tl_v_d;
      br_h_q <= br_h_d;
      br_v_q <= br_v_d;
      h_p0_q <= h_p0_d;
      v_p0_q <= v_p0_d;
      h_p1_q <= h_p1_d;
      v_p1_q <= v_p1_d;
   end

   assign bin_index   = bin_index_q;
   assign busy        = busy_q;
   assign bbox_min_h  = bbox_min_h_q;
   assign bbox_min_v  = bbox_min_v_q;
   assign bbox_max_h  = bbox_max_h_q;
   assign bbox_max_v  = bbox_max_v_q;
   assign hit_count   = hit_count_q;
   assign touch       = touch_q;
   assign touch_h     = touch_h_q;
   assign touch_v     = touch_v_q;
   assign touch_ready = touch_ready_q;

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Bench for blob_bbox_tracker: table vectors for the named frames, randomized frames against
// a direct per-pixel reference, plus pending-request and mid-scan reset sequences.
module tb_blob_bbox_tracker;
   localparam int HS = 28, VS = 22, NPIX = HS * VS, MINC = 4;

   logic        clock = 1'b0, reset = 1'b0, frame_available = 1'b0;
   logic [7:0]  threshold = 8'd128;
   logic [9:0]  roi_tl_h = '0, roi_tl_v = '0, roi_br_h = 10'd27, roi_br_v = 10'd21;
   logic [17:0] bin_index;
   logic [7:0]  pixel_val = '0;
   logic        busy, touch, touch_ready;
   logic [9:0]  bbox_min_h, bbox_min_v, bbox_max_h, bbox_max_v, touch_h, touch_v;
   logic [19:0] hit_count;
   logic [7:0]  mem [1024];

   blob_bbox_tracker #(.HSIZE(HS), .VSIZE(VS), .PIX_W(8), .CW(10), .AW(18), .MIN_COUNT(MINC)) dut (
      .clock(clock), .reset(reset), .frame_available(frame_available), .threshold(threshold),
      .roi_tl_h(roi_tl_h), .roi_tl_v(roi_tl_v), .roi_br_h(roi_br_h), .roi_br_v(roi_br_v),
      .bin_index(bin_index), .pixel_val(pixel_val), .busy(busy),
      .bbox_min_h(bbox_min_h), .bbox_min_v(bbox_min_v), .bbox_max_h(bbox_max_h), .bbox_max_v(bbox_max_v),
      .hit_count(hit_count), .touch(touch), .touch_h(touch_h), .touch_v(touch_v), .touch_ready(touch_ready));

   always #5 clock = ~clock;
   always @(posedge clock) pixel_val <= mem[bin_index[9:0]];

   typedef struct { int cnt, minh, minv, maxh, maxv, tch, th, tv; } res_t;
   typedef struct { int pat, thr, tlh, tlv, brh, brv; res_t exp; } vec_t;

   int   checks = 0, failures = 0;
   int   tr_cyc[4], rise_cyc[4];
   int   tr_n, rise_n, busy_n, addr_err;
   res_t got;
   vec_t vecs[7];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic check_res(input string tag, input res_t a, input res_t e);
      check({tag, "_count"}, a.cnt, e.cnt);
      check({tag, "_min_h"}, a.minh, e.minh);
      check({tag, "_min_v"}, a.minv, e.minv);
      check({tag, "_max_h"}, a.maxh, e.maxh);
      check({tag, "_max_v"}, a.maxv, e.maxv);
      check({tag, "_touch"}, a.tch, e.tch);
      check({tag, "_touch_h"}, a.th, e.th);
      check({tag, "_touch_v"}, a.tv, e.tv);
   endtask

   task automatic load_pat(input int p);
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
      if (p == 1) begin
         for (int v = 3; v <= 6; v++)
            for (int h = 5; h <= 9; h++) mem[v * HS + h] = 8'd255;
      end else if (p == 2) begin
         mem[1 * HS + 2]   = 8'd200;
         mem[15 * HS + 10] = 8'd200;
         mem[4 * HS + 20]  = 8'd200;
         mem[20 * HS + 25] = 8'd127;
      end
   endtask

   function automatic res_t model(input int t, input int tlh, input int tlv, input int brh, input int brv);
      res_t r;
      int n, mnh, mnv, mxh, mxv;
      r = '{default: 0};
      n = 0; mnh = 1 << 20; mnv = 1 << 20; mxh = -1; mxv = -1;
      for (int v = 0; v < VS; v++)
         for (int h = 0; h < HS; h++)
            if (int'(mem[v * HS + h]) >= t && h >= tlh && h <= brh && v >= tlv && v <= brv) begin
               n++;
               if (h < mnh) mnh = h;
               if (h > mxh) mxh = h;
               if (v < mnv) mnv = v;
               if (v > mxv) mxv = v;
            end
      if (n > 0) begin
         r.cnt = n; r.minh = mnh; r.minv = mnv; r.maxh = mxh; r.maxv = mxv;
         r.tch = (n >= MINC) ? 1 : 0;
         r.th = (mnh + mxh) / 2;
         r.tv = (mnv + mxv) / 2;
      end
      return r;
   endfunction

   // Cycle c counts edges after the edge that samples the request (cycle 0).
   // p1/p2 are extra request cycles; scramble changes the config inputs after cycle 0.
   task automatic run_scan(input int t, input int tlh, input int tlv, input int brh, input int brv,
                           input int cycles, input int p1, input int p2, input bit scramble);
      int base;
      bit prev;
      @(negedge clock);
      threshold = 8'(t);
      roi_tl_h = 10'(tlh); roi_tl_v = 10'(tlv); roi_br_h = 10'(brh); roi_br_v = 10'(brv);
      frame_available = 1'b1;
      @(posedge clock);
      #1 frame_available = 1'b0;
      if (scramble) begin
         threshold = 8'($urandom);
         roi_tl_h = 10'($urandom_range(0, 27)); roi_br_h = 10'($urandom_range(0, 27));
         roi_tl_v = 10'($urandom_range(0, 21)); roi_br_v = 10'($urandom_range(0, 21));
      end
      tr_n = 0; rise_n = 0; busy_n = 0; addr_err = 0; base = -1; prev = 1'b0;
      for (int c = 1; c <= cycles; c++) begin
         @(posedge clock);
         #1;
         if (busy) begin
            busy_n++;
            if (!prev) begin
               if (rise_n < 4) rise_cyc[rise_n] = c;
               rise_n++;
               base = c;
            end
         end
         prev = busy;
         if (base >= 0 && (c - base) < NPIX && int'(bin_index) != (c - base)) addr_err++;
         if (touch_ready) begin
            if (tr_n < 4) tr_cyc[tr_n] = c;
            tr_n++;
            got = '{int'(hit_count), int'(bbox_min_h), int'(bbox_min_v), int'(bbox_max_h),
                    int'(bbox_max_v), int'(touch), int'(touch_h), int'(touch_v)};
         end
         frame_available = (c == p1 - 1) || (c == p2 - 1);
      end
   endtask

   initial begin
      res_t e;
      int t, a, b, cc, d, tr, bz;
      for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
      got = '{default: 0};
      repeat (3) @(posedge clock);
      #1;
      check("reset_busy", int'(busy), 0);
      check("reset_touch_ready", int'(touch_ready), 0);
      check("reset_hit_count", int'(hit_count), 0);
      check("reset_bin_index", int'(bin_index), 0);
      check("reset_bbox_max_h", int'(bbox_max_h), 0);
      check("reset_touch", int'(touch), 0);
      @(negedge clock) reset = 1'b1;

      vecs[0] = '{0, 128, 0, 0, 27, 21, '{0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[1] = '{1, 128, 0, 0, 27, 21, '{20, 5, 3, 9, 6, 1, 7, 4}};
      vecs[2] = '{2, 128, 0, 0, 27, 21, '{3, 2, 1, 20, 15, 0, 11, 8}};
      vecs[3] = '{2, 127, 0, 0, 27, 21, '{4, 2, 1, 25, 20, 1, 13, 10}};
      vecs[4] = '{1, 128, 7, 0, 27, 21, '{12, 7, 3, 9, 6, 1, 8, 4}};
      vecs[5] = '{1, 128, 20, 0, 10, 21, '{0, 0, 0, 0, 0, 0, 0, 0}};
      vecs[6] = '{1, 0, 0, 0, 27, 21, '{616, 0, 0, 27, 21, 1, 13, 10}};

      for (int i = 0; i < 7; i++) begin
         load_pat(vecs[i].pat);
         run_scan(vecs[i].thr, vecs[i].tlh, vecs[i].tlv, vecs[i].brh, vecs[i].brv, 640, -1, -1, 1'b0);
         check($sformatf("vec%0d_ready_pulses", i), tr_n, 1);
         check($sformatf("vec%0d_ready_cycle", i), tr_cyc[0], NPIX + 2);
         check($sformatf("vec%0d_busy_rise", i), rise_cyc[0], 1);
         check($sformatf("vec%0d_busy_cycles", i), busy_n, NPIX + 1);
         check($sformatf("vec%0d_addr_errors", i), addr_err, 0);
         check_res($sformatf("vec%0d", i), got, vecs[i].exp);
      end

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NPIX; i++)
            mem[i] = (r % 2 == 0 || $urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd0;
         t = $urandom_range(0, 255);
         a = $urandom_range(0, 27); b = $urandom_range(0, 21);
         cc = $urandom_range(0, 27); d = $urandom_range(0, 21);
         e = model(t, a, b, cc, d);
         run_scan(t, a, b, cc, d, 640, -1, -1, 1'b1);
         check($sformatf("rand%0d_ready_pulses", r), tr_n, 1);
         check_res($sformatf("rand%0d", r), got, e);
      end

      load_pat(1);
      run_scan(128, 0, 0, 27, 21, 2000, 300, 400, 1'b0);
      check("pending_ready_pulses", tr_n, 2);
      check("pending_first_ready", tr_cyc[0], NPIX + 2);
      check("pending_second_ready", tr_cyc[1], 2 * (NPIX + 4) - 2);
      check("pending_scans", rise_n, 2);
      check("pending_second_busy_rise", rise_cyc[1], NPIX + 5);
      check("pending_addr_errors", addr_err, 0);
      check("pending_second_count", got.cnt, 20);

      @(negedge clock);
      threshold = 8'd128; frame_available = 1'b1;
      @(posedge clock);
      #1 frame_available = 1'b0;
      repeat (199) @(posedge clock);
      #1;
      check("midscan_busy_before_reset", int'(busy), 1);
      check("midscan_count_before_reset", int'(hit_count), 20);
      reset = 1'b0;
      #1;
      check("midscan_reset_busy", int'(busy), 0);
      check("midscan_reset_hit_count", int'(hit_count), 0);
      check("midscan_reset_bbox_max_h", int'(bbox_max_h), 0);
      check("midscan_reset_touch_h", int'(touch_h), 0);
      check("midscan_reset_touch", int'(touch), 0);
      check("midscan_reset_bin_index", int'(bin_index), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      tr = 0; bz = 0;
      for (int c = 0; c < 700; c++) begin
         @(posedge clock);
         #1;
         if (touch_ready) tr++;
         if (busy) bz++;
      end
      check("after_reset_ready_pulses", tr, 0);
      check("after_reset_busy_cycles", bz, 0);
      e = model(128, 0, 0, 27, 21);
      run_scan(128, 0, 0, 27, 21, 640, -1, -1, 1'b0);
      check("fresh_ready_cycle", tr_cyc[0], NPIX + 2);
      check("fresh_ready_pulses", tr_n, 1);
      check_res("fresh", got, e);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
